// File: rtl/lockout_timer_pkg.sv
//------------------------------------------------------------------------------
// Module   : lockout_timer_pkg
// Purpose  : Shared state encoding and mode constants for the lockout timer.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package lockout_timer_pkg;

  // Two-state controller: waiting for a start, or counting a period down.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Value of the mode input latched on start.
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

`default_nettype wire

// File: rtl/lockout_timer_if.sv
//------------------------------------------------------------------------------
// Module   : lockout_timer_if
// Purpose  : Control/status bundle between the lock FSM (master) and the
//            lockout timer (slave).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface lockout_timer_if #(
  parameter int CNT_W = 9
);
  logic             start;
  logic             cancel;
  logic             mode;
  logic [CNT_W-1:0] limit_i;
  logic             busy;
  logic             expire;
  logic [CNT_W-1:0] remaining;

  modport master (
    output start, cancel, mode, limit_i,
    input  busy, expire, remaining
  );

  modport slave (
    input  start, cancel, mode, limit_i,
    output busy, expire, remaining
  );
endinterface

`default_nettype wire

// File: rtl/lockout_timer_tick_prescaler.sv
//------------------------------------------------------------------------------
// Module   : tick_prescaler
// Purpose  : Emits a one-cycle tick every PRESCALE enabled clock cycles.
//            With PRESCALE=1 the tick simply follows en.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clr,
  input  wire logic en,
  output logic      tick
);

  // At least one bit so PRESCALE=1 still has a legal (constant-zero) counter.
  localparam int c_CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(PRESCALE - 1);

  logic [c_CW-1:0] r_cnt;

  // Tick is combinational from the counter so the controller can act on it
  // in the same cycle a start or cancel arrives.
  assign tick = en && (r_cnt == c_LAST);

  // Cycle counter: cleared on request, wraps to zero on every tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lockout_timer.sv
//------------------------------------------------------------------------------
// Module   : lockout_timer
// Purpose  : Parametrised countdown timer with prescaler, one-shot/periodic
//            mode and cancel/restart. Drives busy (display window) and a
//            single-cycle expire pulse at the end of every period.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module lockout_timer
  import lockout_timer_pkg::*;
#(
  parameter int CNT_W         = 9,
  parameter int DEFAULT_LIMIT = 220,
  parameter int PRESCALE      = 1
) (
  input  wire logic       clk,
  input  wire logic       rst,
  lockout_timer_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_DEFAULT = CNT_W'(DEFAULT_LIMIT);
  localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_remaining, w_rem_nxt;
  logic [CNT_W-1:0] r_limit;
  logic             r_mode;
  logic             r_busy;
  logic             r_expire, w_expire_nxt;
  logic             w_load;
  logic [CNT_W-1:0] w_eff_limit;
  logic             w_tick;
  logic             w_final;
  logic             w_pre_clr;
  logic             w_pre_en;

  assign w_eff_limit = (bus.limit_i == '0) ? c_DEFAULT : bus.limit_i;
  assign w_final     = w_tick && (r_remaining == c_ONE);

  // The prescaler only runs while counting and restarts its phase on any
  // start or cancel so each period begins with a full PRESCALE interval.
  assign w_pre_en  = (r_state == ST_RUN);
  assign w_pre_clr = (r_state == ST_IDLE) || bus.start || bus.cancel;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_pre_clr),
    .en   (w_pre_en),
    .tick (w_tick)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, counter and expire; priority in RUN is cancel > start > tick.
  always_comb begin
    w_state_nxt  = r_state;
    w_rem_nxt    = r_remaining;
    w_expire_nxt = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start && !bus.cancel) begin
          w_state_nxt = ST_RUN;
          w_rem_nxt   = w_eff_limit;
          w_load      = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.cancel) begin
          w_state_nxt = ST_IDLE;
          w_rem_nxt   = '0;
        end else if (bus.start) begin
          // A restart landing on the final tick still reports that period.
          w_rem_nxt    = w_eff_limit;
          w_load       = 1'b1;
          w_expire_nxt = w_final;
        end else if (w_final) begin
          w_expire_nxt = 1'b1;
          if (r_mode == MODE_PERIODIC) begin
            w_rem_nxt = r_limit;
          end else begin
            w_state_nxt = ST_IDLE;
            w_rem_nxt   = '0;
          end
        end else if (w_tick) begin
          w_rem_nxt = r_remaining - c_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_rem_nxt   = '0;
      end
    endcase
  end

  // Datapath and output registers; limit and mode latch on every accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_remaining <= '0;
      r_limit     <= '0;
      r_mode      <= MODE_ONESHOT;
      r_busy      <= 1'b0;
      r_expire    <= 1'b0;
    end else begin
      r_remaining <= w_rem_nxt;
      r_busy      <= (w_state_nxt == ST_RUN);
      r_expire    <= w_expire_nxt;
      if (w_load) begin
        r_limit <= w_eff_limit;
        r_mode  <= bus.mode;
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.expire    = r_expire;
  assign bus.remaining = r_remaining;

endmodule

`default_nettype wire
